// File: rtl/keypad_loop_recorder_if.sv
// Keypad-side signal bundle of the loop recorder: live keys and transport
// commands towards the recorder, synthetic keypad vector and status back.
interface keypad_loop_recorder_if #(
    parameter int DEPTH = 16
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic [14:0]      keypad_i;
    logic             rec_start;
    logic             play_start;
    logic             stop;
    logic [14:0]      keypad_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] count_o;
    logic             full;

    modport master (
        output en, keypad_i, rec_start, play_start, stop,
        input  keypad_o, state_o, count_o, full
    );

    modport slave (
        input  en, keypad_i, rec_start, play_start, stop,
        output keypad_o, state_o, count_o, full
    );
endinterface

// File: rtl/keypad_loop_recorder.sv
// Records the keypad vector as (vector, duration) segments and replays them in
// a loop; live keys pass straight through whenever it is not playing.
module keypad_loop_recorder #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 12000,
    parameter int DUR_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_loop_recorder_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};
    localparam logic [DUR_W-1:0] DUR_SPLIT = DUR_MAX - 1'b1;
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REC  = 2'b01,
        S_PLAY = 2'b10
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full_reg;
    logic [PRE_W-1:0] presc_reg;
    logic [DUR_W-1:0] dur_reg;
    logic [14:0]      cur_vec_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [DUR_W-1:0] remain_reg;
    logic [14:0]      play_vec_reg;

    logic [14:0]      vec_mem [DEPTH];
    logic [DUR_W-1:0] dur_mem [DEPTH];

    logic             tick;
    logic             key_change;
    logic             dur_zero;
    logic             seg_saturate;
    logic             cmd_stop;
    logic             cmd_rec;
    logic             cmd_play;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [14:0]      wr_vec;
    logic [DUR_W-1:0] wr_dur;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] ptr_inc;
    logic [PTR_W-1:0] rd_ptr_adv;

    assign tick       = bus.en && (presc_reg == PRE_LAST);
    assign key_change = (bus.keypad_i != cur_vec_reg);
    assign dur_zero   = (dur_reg == '0);
    // Split as soon as a segment reaches the longest storable length, so the
    // follow-on segment starts counting from the very next tick.
    assign seg_saturate = tick && (dur_reg == DUR_SPLIT);

    // stop outranks rec_start, which outranks play_start
    assign cmd_stop = bus.en && bus.stop;
    assign cmd_rec  = bus.en && bus.rec_start && !bus.stop;
    assign cmd_play = bus.en && bus.play_start && !bus.stop && !bus.rec_start
                      && (state_reg != S_REC) && (count_reg != '0);

    always_comb begin
        wr_en   = 1'b0;
        wr_vec  = cur_vec_reg;
        wr_dur  = dur_reg;
        wr_addr = PTR_W'(count_reg);
        if (bus.en && state_reg == S_REC) begin
            if (bus.stop) begin
                wr_en = !dur_zero && !full_reg;
            end else if (!bus.rec_start) begin
                if (key_change) begin
                    // a segment shorter than one tick is dropped as a glitch
                    wr_en = !dur_zero;
                end else if (seg_saturate) begin
                    wr_en  = 1'b1;
                    wr_dur = DUR_MAX;
                end
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (cmd_rec) begin
            count_next = '0;
        end else if (wr_en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_comb begin
        ptr_inc    = CNT_W'(rd_ptr_reg) + 1'b1;
        rd_ptr_adv = (ptr_inc == count_reg) ? '0 : PTR_W'(ptr_inc);
    end

    // Entry storage; contents are only meaningful below count_reg.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            vec_mem[wr_addr] <= wr_vec;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            presc_reg    <= '0;
            dur_reg      <= '0;
            cur_vec_reg  <= '0;
            rd_ptr_reg   <= '0;
            remain_reg   <= '0;
            play_vec_reg <= '0;
        end else if (bus.en) begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_FULL);

            if (cmd_stop) begin
                state_reg <= S_IDLE;
            end else if (cmd_rec) begin
                state_reg   <= S_REC;
                cur_vec_reg <= bus.keypad_i;
                dur_reg     <= '0;
                presc_reg   <= '0;
            end else if (cmd_play) begin
                state_reg    <= S_PLAY;
                rd_ptr_reg   <= '0;
                play_vec_reg <= vec_mem[0];
                remain_reg   <= dur_mem[0];
                presc_reg    <= '0;
            end else begin
                case (state_reg)
                    S_REC: begin
                        if (key_change) begin
                            cur_vec_reg <= bus.keypad_i;
                            dur_reg     <= (dur_zero && tick) ? DUR_ONE : '0;
                        end else if (tick) begin
                            dur_reg <= seg_saturate ? '0 : dur_reg + 1'b1;
                        end
                        if (wr_en && count_next == CNT_FULL) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    S_PLAY: begin
                        if (tick) begin
                            if (remain_reg <= DUR_ONE) begin
                                rd_ptr_reg   <= rd_ptr_adv;
                                play_vec_reg <= vec_mem[rd_ptr_adv];
                                remain_reg   <= dur_mem[rd_ptr_adv];
                            end else begin
                                remain_reg <= remain_reg - 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.keypad_o = (state_reg == S_PLAY) ? play_vec_reg : bus.keypad_i;
    assign bus.state_o  = state_reg;
    assign bus.count_o  = count_reg;
    assign bus.full     = full_reg;
endmodule

// File: tb/tb_keypad_loop_recorder.sv
// Directed bench for the keypad loop recorder: recorded segments are known from
// the stimulus, and playback is checked cycle by cycle against a queue.
module tb_keypad_loop_recorder;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   play_chk = 1'b0;
    logic [14:0] exp_q [$];
    logic [14:0] keys [6] = '{15'h0100, 15'h0200, 15'h0400, 15'h0800, 15'h1000, 15'h2000};

    always #5 clk = ~clk;

    keypad_loop_recorder_if #(.DEPTH(DEPTH)) bus ();

    keypad_loop_recorder #(
        .DEPTH(DEPTH),
        .TICK_DIV(TICK_DIV),
        .DUR_W(DUR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] st, input int cnt, input logic fl);
        check({tag, ".state"}, 32'(bus.state_o), 32'(st));
        check({tag, ".count"}, 32'(bus.count_o), 32'(unsigned'(cnt)));
        check({tag, ".full"},  32'(bus.full),    32'(fl));
    endtask

    // One clock; outputs are sampled on the falling edge.
    task automatic cycle();
        logic [14:0] e;
        @(posedge clk);
        @(negedge clk);
        if (play_chk && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("play_vec", 32'(bus.keypad_o), 32'(e));
        end
    endtask

    task automatic pulse(input logic rec, input logic play, input logic stp);
        $display("%0t cmd rec=%0b play=%0b stop=%0b en=%0b keys=0x%04h",
                 $time, rec, play, stp, bus.en, bus.keypad_i);
        bus.rec_start  = rec;
        bus.play_start = play;
        bus.stop       = stp;
        cycle();
        bus.rec_start  = 1'b0;
        bus.play_start = 1'b0;
        bus.stop       = 1'b0;
    endtask

    task automatic push_seg(input logic [14:0] vec, input int ticks);
        repeat (ticks * TICK_DIV) exp_q.push_back(vec);
    endtask

    task automatic run_play(input string tag);
        while (exp_q.size() > 0) cycle();
        $display("%0t playback %s consumed, checks=%0d", $time, tag, checks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en         = 1'b1;
        bus.keypad_i   = 15'h0ABC;
        bus.rec_start  = 1'b0;
        bus.play_start = 1'b0;
        bus.stop       = 1'b0;
        repeat (3) @(negedge clk);
        check_status("reset", 2'b00, 0, 1'b0);
        check("reset.pass", 32'(bus.keypad_o), 32'h0ABC);
        rst = 1'b0;
        cycle();

        // two notes: 12 cycles of 0x0001, 8 cycles of 0x0004
        bus.keypad_i = 15'h0001;
        pulse(1'b1, 1'b0, 1'b0);
        check_status("rec2.start", 2'b01, 0, 1'b0);
        check("rec2.pass", 32'(bus.keypad_o), 32'h0001);
        repeat (12) cycle();
        bus.keypad_i = 15'h0004;
        repeat (8) cycle();
        pulse(1'b0, 1'b0, 1'b1);
        check_status("rec2.done", 2'b00, 2, 1'b0);

        // looped playback of the two notes
        push_seg(15'h0001, 3);
        push_seg(15'h0004, 2);
        push_seg(15'h0001, 3);
        play_chk = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        check("play2.state", 32'(bus.state_o), 32'h2);
        run_play("two_notes");
        play_chk = 1'b0;
        bus.keypad_i = 15'h7FFF;
        pulse(1'b0, 1'b0, 1'b1);
        check("play2.stop_state", 32'(bus.state_o), 32'h0);
        check("play2.stop_pass", 32'(bus.keypad_o), 32'h7FFF);

        // asynchronous reset in the middle of playback
        bus.keypad_i = 15'h1234;
        pulse(1'b0, 1'b1, 1'b0);
        repeat (5) cycle();
        check("rstp.pre_state", 32'(bus.state_o), 32'h2);
        check("rstp.pre_vec", 32'(bus.keypad_o), 32'h0001);
        #2 rst = 1'b1;
        #1;
        check_status("rstp", 2'b00, 0, 1'b0);
        check("rstp.pass", 32'(bus.keypad_o), 32'h1234);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // glitch filter and saturation split
        bus.keypad_i = 15'h0020;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (8) cycle();
        bus.keypad_i = 15'h0040;
        repeat (2) cycle();
        bus.keypad_i = 15'h0010;
        repeat (39) cycle();
        pulse(1'b0, 1'b0, 1'b1);
        check_status("glsat", 2'b00, 3, 1'b0);
        push_seg(15'h0020, 2);
        push_seg(15'h0010, 7);
        push_seg(15'h0010, 3);
        push_seg(15'h0020, 2);
        play_chk = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        run_play("glitch_sat");
        play_chk = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);

        // five key changes into a four-entry memory
        bus.keypad_i = keys[0];
        pulse(1'b1, 1'b0, 1'b0);
        repeat (8) cycle();
        for (int k = 1; k < 6; k++) begin
            bus.keypad_i = keys[k];
            repeat (8) cycle();
        end
        check_status("full", 2'b00, 4, 1'b1);

        // enable freeze mid-playback, with a stop pulse that must be ignored
        push_seg(keys[0], 2);
        repeat (20) exp_q.push_back(keys[0]);
        push_seg(keys[1], 2);
        push_seg(keys[2], 2);
        push_seg(keys[3], 2);
        push_seg(keys[0], 2);
        play_chk = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        repeat (4) cycle();
        bus.en = 1'b0;
        repeat (10) cycle();
        pulse(1'b0, 1'b0, 1'b1);
        repeat (9) cycle();
        bus.en = 1'b1;
        run_play("freeze");
        play_chk = 1'b0;
        check("frz.state", 32'(bus.state_o), 32'h2);

        // stop and rec_start together while playing: stop wins
        pulse(1'b1, 1'b0, 1'b1);
        check_status("prio", 2'b00, 4, 1'b1);
        check("prio.pass", 32'(bus.keypad_o), 32'(keys[5]));

        // empty memory: play_start is ignored
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_status("clr", 2'b00, 0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("empty.state", 32'(bus.state_o), 32'h0);
        check("empty.pass", 32'(bus.keypad_o), 32'(keys[5]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
